// File: rtl/slave_mem_if.sv
// Request/response bus between a crossbar slave port and a memory-mapped slave.
// The crossbar drives the request side; the slave drives the acceptance and read-return side.
`ifndef DW
`define DW 32
`endif

interface slave_mem_if #(
  parameter int AW = 30,
  parameter int DW = `DW
);
  logic          req;
  logic          cmd;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic          resp;
  logic [DW-1:0] rdata;

  modport master (output req, cmd, addr, wdata, input  ack, resp, rdata);
  modport slave  (input  req, cmd, addr, wdata, output ack, resp, rdata);
endinterface

// File: rtl/slave_mem.sv
// Latency-configurable memory slave: one outstanding request, fixed ack and read-response delays.
// Requests arriving while a transaction is in flight are discarded and counted.
`ifndef DW
`define DW 32
`endif

module slave_mem #(
  parameter int SLAVES   = 4,
  parameter int DW       = `DW,
  parameter int DEPTH    = 16,
  parameter int ACK_LAT  = 2,
  parameter int RESP_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  slave_mem_if.slave  bus,
  output logic [7:0]  drop_cnt
);
  localparam int AW = 32 - $clog2(SLAVES);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ACK_WAIT, RESP_WAIT} state_t;

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_cnt, w_cnt_nxt;
  logic            r_cmd;
  logic [IW-1:0]   r_idx;
  logic [DW-1:0]   r_wdata;
  logic [DW-1:0]   r_word;
  logic [DW-1:0]   r_rdata;
  logic            r_ack, r_resp;
  logic [7:0]      r_drop;
  logic [DEPTH-1:0] r_written;
  logic [DW-1:0]   r_mem [DEPTH];

  logic w_accept, w_drop, w_do_ack, w_do_write, w_do_resp;
  logic w_unused_addr;

  // Upper address bits alias onto the same words.
  assign w_unused_addr = ^bus.addr[AW-1:IW];

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_drop      = 1'b0;
    w_do_ack    = 1'b0;
    w_do_write  = 1'b0;
    w_do_resp   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = 4'(ACK_LAT - 1);
          w_state_nxt = ACK_WAIT;
        end
      end
      ACK_WAIT: begin
        w_drop = bus.req;
        if (r_cnt == 4'd0) begin
          w_do_ack = 1'b1;
          if (r_cmd) begin
            w_do_write  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt   = 4'(RESP_LAT - 1);
            w_state_nxt = RESP_WAIT;
          end
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      RESP_WAIT: begin
        w_drop = bus.req;
        if (r_cnt == 4'd0) begin
          w_do_resp   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_cmd     <= 1'b0;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_word    <= '0;
      r_rdata   <= '0;
      r_ack     <= 1'b0;
      r_resp    <= 1'b0;
      r_drop    <= '0;
      r_written <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ack   <= w_do_ack;
      r_resp  <= w_do_resp;
      if (w_accept) begin
        r_cmd   <= bus.cmd;
        r_idx   <= bus.addr[IW-1:0];
        r_wdata <= bus.wdata;
      end
      if (w_do_write)
        r_written[r_idx] <= 1'b1;
      // Unwritten words read as zero regardless of what the array holds.
      if (w_do_ack && !r_cmd)
        r_word <= r_written[r_idx] ? r_mem[r_idx] : '0;
      if (w_do_resp)
        r_rdata <= r_word;
      if (w_drop && (r_drop != 8'hFF))
        r_drop <= r_drop + 8'd1;
    end
  end

  // NOTE: the storage array has no reset; the written flags above make stale contents invisible.
  always_ff @(posedge clk) begin
    if (w_do_write)
      r_mem[r_idx] <= r_wdata;
  end

  assign bus.ack   = r_ack;
  assign bus.resp  = r_resp;
  assign bus.rdata = r_rdata;
  assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_slave_mem.sv
// Scoreboard bench for slave_mem: a cycle-level model predicts ack/resp cycles, read data and drops.
module tb_slave_mem;
  localparam int AW       = 30;
  localparam int DW       = 32;
  localparam int DEPTH    = 16;
  localparam int ACK_LAT  = 2;
  localparam int RESP_LAT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] drop_cnt;

  slave_mem_if #(.AW(AW), .DW(DW)) bus();

  slave_mem #(
    .SLAVES(4), .DW(DW), .DEPTH(DEPTH), .ACK_LAT(ACK_LAT), .RESP_LAT(RESP_LAT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          at;
  } rd_t;

  rd_t         rq[$];
  int          aq[$];
  rd_t         e;
  logic [31:0] m_mem [DEPTH];
  bit          m_wr  [DEPTH];
  int          free_edge = 0;
  int          exp_drop  = 0;
  int          n_checks  = 0;
  int          n_errors  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drive one request for one cycle; the model decides acceptance and queues expectations.
  task automatic issue(input logic c, input logic [AW-1:0] a, input logic [31:0] d);
    int k;
    logic [3:0] idx;
    k   = cyc + 1;
    idx = a[3:0];
    bus.req = 1'b1; bus.cmd = c; bus.addr = a; bus.wdata = d;
    if (k >= free_edge) begin
      aq.push_back(k + ACK_LAT);
      if (c) begin
        m_mem[idx] = d;
        m_wr[idx]  = 1'b1;
        free_edge  = k + ACK_LAT + 1;
      end else begin
        rq.push_back('{data: (m_wr[idx] ? m_mem[idx] : 32'h0), at: k + ACK_LAT + RESP_LAT});
        free_edge = k + ACK_LAT + RESP_LAT + 1;
      end
    end else if (exp_drop < 255) begin
      exp_drop++;
    end
    @(negedge clk);
    bus.req = 1'b0;
  endtask

  task automatic wait_free();
    while (cyc + 1 < free_edge) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    aq.delete();
    rq.delete();
    foreach (m_wr[i]) m_wr[i] = 1'b0;
    exp_drop  = 0;
    free_edge = 0;
    #1;
    check("rst_ack",   {31'b0, bus.ack},  32'h0);
    check("rst_resp",  {31'b0, bus.resp}, 32'h0);
    check("rst_rdata", bus.rdata,         32'h0);
    check("rst_drop",  {24'b0, drop_cnt}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (bus.ack && bus.resp) check("ack_resp_excl", 32'h1, 32'h0);
      if (bus.ack) begin
        if (aq.size() == 0) check("ack_unexpected", 32'h1, 32'h0);
        else                check("ack_cycle", cyc, aq.pop_front());
      end
      if (bus.resp) begin
        if (rq.size() == 0) begin
          check("resp_unexpected", 32'h1, 32'h0);
        end else begin
          e = rq.pop_front();
          check("resp_cycle", cyc, e.at);
          check("rdata", bus.rdata, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req = 1'b0; bus.cmd = 1'b0; bus.addr = '0; bus.wdata = '0;
    foreach (m_wr[i]) m_wr[i] = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("por_ack",   {31'b0, bus.ack},  32'h0);
    check("por_resp",  {31'b0, bus.resp}, 32'h0);
    check("por_rdata", bus.rdata,         32'h0);
    check("por_drop",  {24'b0, drop_cnt}, 32'h0);
    rst = 1'b1;

    // Read of never-written word returns zero
    issue(1'b0, 30'd5, 32'h0);
    wait_free();

    // Write, then read issued right after the write ack; data must hold afterwards
    issue(1'b1, 30'd3, 32'hDEADBEEF);
    wait_free();
    issue(1'b0, 30'd3, 32'h0);
    wait_free();
    repeat (7) @(negedge clk);
    check("rdata_hold", bus.rdata, 32'hDEADBEEF);

    // Back-to-back: next request during the write ack cycle is accepted
    issue(1'b1, 30'd1, 32'h11);
    wait_free();
    issue(1'b0, 30'd1, 32'h0);
    check("drop_b2b", {24'b0, drop_cnt}, 32'(exp_drop));
    wait_free();

    // Single drop while in ACK_WAIT
    issue(1'b0, 30'd1, 32'h0);
    issue(1'b0, 30'd2, 32'h0);
    check("drop_one", {24'b0, drop_cnt}, 32'(exp_drop));
    wait_free();

    // Continuous random request stream: saturates drop counter
    for (int i = 0; i < 400; i++)
      issue(1'($urandom_range(0, 1)), AW'($urandom), $urandom);
    check("drop_sat", {24'b0, drop_cnt}, 32'(exp_drop));
    check("drop_255", {24'b0, drop_cnt}, 32'd255);
    wait_free();

    // Aliasing of upper address bits
    issue(1'b1, 30'h13, 32'hA1A5_0013);
    wait_free();
    issue(1'b0, 30'd3, 32'h0);
    wait_free();

    // Reset while waiting for read response
    issue(1'b1, 30'd7, 32'h7777_0007);
    wait_free();
    issue(1'b0, 30'd7, 32'h0);
    repeat (ACK_LAT) @(negedge clk);
    do_reset();
    issue(1'b0, 30'd7, 32'h0);
    wait_free();

    // Reset before a write's ack edge: write must not land
    issue(1'b1, 30'd9, 32'h9999_0009);
    do_reset();
    issue(1'b0, 30'd9, 32'h0);
    wait_free();

    repeat (3) @(negedge clk);
    check("drop_final",  {24'b0, drop_cnt}, 32'(exp_drop));
    check("ackq_empty",  32'(aq.size()), 32'h0);
    check("respq_empty", 32'(rq.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
